// File: rtl/aemb2_dwb_sio.sv
// Wishbone-attached timer, compare interrupt and TX byte FIFO for the AEMB2 data bus.
// All accesses ack one cycle after the strobe; side effects commit on the ack-raising edge.
module aemb2_dwb_sio #(
   parameter int unsigned TXD_AW  = 2,
   parameter logic [31:0] TMR_RST = 32'h0
) (
   input  logic        sys_clk_i,
   input  logic        sys_rst_i,
   input  logic [1:0]  dwb_adr_i,
   input  logic [31:0] dwb_dat_i,
   input  logic [3:0]  dwb_sel_i,
   input  logic        dwb_stb_i,
   input  logic        dwb_wre_i,
   output logic        dwb_ack_o,
   output logic [31:0] dwb_dat_o,
   output logic        sys_int_o,
   output logic [7:0]  tx_dat_o,
   output logic        tx_stb_o,
   input  logic        tx_ack_i
);

   localparam int unsigned Depth = 1 << TXD_AW;
   localparam logic [TXD_AW:0]   CntFull = (TXD_AW+1)'(Depth);
   localparam logic [TXD_AW:0]   CntOne  = (TXD_AW+1)'(1);
   localparam logic [TXD_AW-1:0] PtrOne  = TXD_AW'(1);

   logic              ack_q, ack_d;
   logic [31:0]       dat_q, dat_d;
   logic [31:0]       tmr_q, tmr_d, cmp_q, cmp_d;
   logic              pnd_q, pnd_d, ien_q, ien_d, ovf_q, ovf_d, int_q;
   logic [TXD_AW:0]   cnt_q, cnt_d;
   logic [TXD_AW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [7:0]        mem_q [Depth];

   logic        acc, wr, rd, full, empty, pop, push, push_ok, drop, hit;
   logic        tmr_wr, cmp_wr, isr_wr;
   logic [2:0]  cnt3;
   logic [31:0] rdata;

   // An access is taken only on the first strobe cycle; the ack cycle masks the second.
   assign acc     = dwb_stb_i & ~ack_q;
   assign wr      = acc & dwb_wre_i;
   assign rd      = acc & ~dwb_wre_i;
   assign tmr_wr  = wr & (dwb_adr_i == 2'd0) & (dwb_sel_i == 4'hF);
   assign cmp_wr  = wr & (dwb_adr_i == 2'd1) & (dwb_sel_i == 4'hF);
   assign push    = wr & (dwb_adr_i == 2'd2) & dwb_sel_i[3];
   assign isr_wr  = wr & (dwb_adr_i == 2'd3) & dwb_sel_i[0];
   assign full    = (cnt_q == CntFull);
   assign empty   = (cnt_q == '0);
   assign pop     = ~empty & tx_ack_i;
   assign push_ok = push & (~full | pop);
   assign drop    = push & full & ~pop;
   assign hit     = (tmr_q == cmp_q);
   assign cnt3    = 3'(cnt_q);

   always_comb begin
      rdata = '0;
      unique case (dwb_adr_i)
         2'd0: rdata = tmr_q;
         2'd1: rdata = cmp_q;
         2'd2: rdata = {24'h0, full, empty, 3'b000, cnt3};
         2'd3: rdata = {29'h0, ovf_q, ien_q, pnd_q};
         default: rdata = '0;
      endcase
   end

   always_comb begin
      ack_d = acc;
      dat_d = rd ? rdata : 32'h0;
      tmr_d = tmr_wr ? dwb_dat_i : tmr_q + 32'd1;
      cmp_d = cmp_wr ? dwb_dat_i : cmp_q;
      pnd_d = pnd_q;
      ovf_d = ovf_q;
      ien_d = ien_q;
      if (isr_wr) begin
         pnd_d = pnd_q & ~dwb_dat_i[0];
         ovf_d = ovf_q & ~dwb_dat_i[2];
         ien_d = dwb_dat_i[1];
      end
      // Set events win over a same-edge clear.
      if (hit)  pnd_d = 1'b1;
      if (drop) ovf_d = 1'b1;
      wp_d  = push_ok ? wp_q + PtrOne : wp_q;
      rp_d  = pop ? rp_q + PtrOne : rp_q;
      cnt_d = cnt_q;
      unique case ({push_ok, pop})
         2'b10:   cnt_d = cnt_q + CntOne;
         2'b01:   cnt_d = cnt_q - CntOne;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         ack_q <= 1'b0;
         dat_q <= 32'h0;
         tmr_q <= TMR_RST;
         cmp_q <= 32'hFFFF_FFFF;
         pnd_q <= 1'b0;
         ien_q <= 1'b0;
         ovf_q <= 1'b0;
         int_q <= 1'b0;
         cnt_q <= '0;
         wp_q  <= '0;
         rp_q  <= '0;
      end else begin
         ack_q <= ack_d;
         dat_q <= dat_d;
         tmr_q <= tmr_d;
         cmp_q <= cmp_d;
         pnd_q <= pnd_d;
         ien_q <= ien_d;
         ovf_q <= ovf_d;
         int_q <= pnd_q & ien_q;
         cnt_q <= cnt_d;
         wp_q  <= wp_d;
         rp_q  <= rp_d;
      end
   end

   always_ff @(posedge sys_clk_i) begin
      if (push_ok && !sys_rst_i) mem_q[wp_q] <= dwb_dat_i[31:24];
   end

   assign dwb_ack_o = ack_q;
   assign dwb_dat_o = dat_q;
   assign sys_int_o = int_q;
   assign tx_stb_o  = ~empty;
   assign tx_dat_o  = mem_q[rp_q];

endmodule

// File: tb/tb_aemb2_dwb_sio.sv
// Scoreboard bench: bus accesses push expected read data; a negedge monitor checks acks and TX bytes.
module tb_aemb2_dwb_sio;

   logic        clk = 1'b0, rst = 1'b1;
   logic [1:0]  adr = '0;
   logic [31:0] wdat = '0;
   logic [3:0]  sel = '0;
   logic        stb = 1'b0, wre = 1'b0, tx_ack = 1'b0;
   logic        ack, irq, txs;
   logic [31:0] rdat;
   logic [7:0]  txd;

   aemb2_dwb_sio dut (
      .sys_clk_i (clk),
      .sys_rst_i (rst),
      .dwb_adr_i (adr),
      .dwb_dat_i (wdat),
      .dwb_sel_i (sel),
      .dwb_stb_i (stb),
      .dwb_wre_i (wre),
      .dwb_ack_o (ack),
      .dwb_dat_o (rdat),
      .sys_int_o (irq),
      .tx_dat_o  (txd),
      .tx_stb_o  (txs),
      .tx_ack_i  (tx_ack)
   );

   initial forever #5 clk = ~clk;

   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0, n_err = 0;
   bit mon_en = 1'b0;

   typedef struct { bit chk; logic [31:0] exp; } rsp_t;
   rsp_t exp_q[$];

   // Reference model: timer as a linear function of edge number, FIFO as a queue.
   logic [31:0] tmr_v, cmp_m;
   longint      tmr_l, eval_e, pop_edge = -1;
   bit          pnd_m, ien_m, ovf_m;
   logic [7:0]  fifo_m[$];

   function automatic logic [31:0] tmr_at(longint e);
      return tmr_v + 32'(e - 1 - tmr_l);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Any compare hit on edges after eval_e up to e_last latches PND.
   task automatic advance(input longint e_last);
      longint n;
      logic [31:0] k;
      n = e_last - eval_e;
      if (n > 0) begin
         k = cmp_m - tmr_at(eval_e + 1);
         if (longint'(k) < n) pnd_m = 1'b1;
         eval_e = e_last;
      end
   endtask

   task automatic model_access(input longint e, input logic [1:0] a, input logic w,
                               input logic [31:0] d, input logic [3:0] s,
                               output logic [31:0] r);
      bit hit;
      int cnt;
      advance(e - 1);
      hit = (tmr_at(e) == cmp_m);
      cnt = fifo_m.size() + ((pop_edge == e) ? 1 : 0);
      case (a)
         2'd0: r = tmr_at(e);
         2'd1: r = cmp_m;
         2'd2: r = {24'h0, cnt == 4, cnt == 0, 3'b000, 3'(cnt)};
         default: r = {29'h0, ovf_m, ien_m, pnd_m};
      endcase
      if (w) begin
         case (a)
            2'd0: if (s == 4'hF) begin tmr_v = d; tmr_l = e; end
            2'd1: if (s == 4'hF) cmp_m = d;
            2'd2: if (s[3]) begin
               if (fifo_m.size() < 4) fifo_m.push_back(d[31:24]);
               else ovf_m = 1'b1;
            end
            default: if (s[0]) begin
               pnd_m = pnd_m & ~d[0];
               ovf_m = ovf_m & ~d[2];
               ien_m = d[1];
            end
         endcase
      end
      if (hit) pnd_m = 1'b1;
      eval_e = e;
   endtask

   task automatic bus(input logic [1:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, input bit pulse_ack = 1'b0);
      logic [31:0] r;
      rsp_t rsp;
      adr = a; wre = w; wdat = d; sel = s; stb = 1'b1;
      if (pulse_ack) tx_ack = 1'b1;
      @(posedge clk); #1;
      model_access(cyc, a, w, d, s, r);
      rsp.chk = !w;
      rsp.exp = r;
      exp_q.push_back(rsp);
      stb = 1'b0; wre = 1'b0;
      if (pulse_ack) tx_ack = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b0;
      tmr_v = 32'h0; tmr_l = cyc; eval_e = cyc;
      cmp_m = 32'hFFFF_FFFF;
      pnd_m = 1'b0; ien_m = 1'b0; ovf_m = 1'b0;
      fifo_m.delete();
      exp_q.delete();
      pop_edge = -1;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (ack) begin
            if (exp_q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL spurious_ack: got ack=1 expected no pending access (t=%0t)", $time);
            end else begin
               rsp_t r;
               r = exp_q.pop_front();
               if (r.chk) check("read_data", rdat, r.exp);
            end
         end else begin
            check("dat_idle", rdat, 32'h0);
         end
         check("tx_stb", {31'h0, txs}, {31'h0, fifo_m.size() != 0});
         if (fifo_m.size() != 0 && tx_ack) begin
            check("tx_byte", {24'h0, txd}, {24'h0, fifo_m.pop_front()});
            pop_edge = cyc + 1;
         end
      end
   end

   initial begin
      longint e_hit;
      int guard;
      do_reset(2);
      mon_en = 1'b1;
      check("rst_ack", {31'h0, ack}, 32'h0);
      check("rst_int", {31'h0, irq}, 32'h0);

      // Compare interrupt: CMP=0x10 with IEN set.
      bus(2'd1, 1'b1, 32'h10, 4'hF);
      bus(2'd3, 1'b1, 32'h2, 4'hF);
      e_hit = tmr_l + 1 + longint'(cmp_m - tmr_v);
      if (e_hit <= cyc || e_hit - cyc > 200) begin
         n_vec++; n_err++;
         $display("FAIL hit_window: got edge %0d expected within 200 of %0d", e_hit, cyc);
      end else begin
         while (cyc < e_hit) begin @(posedge clk); #1; end
         check("int_at_hit", {31'h0, irq}, 32'h0);
         @(posedge clk); #1;
         check("int_after_hit", {31'h0, irq}, 32'h1);
      end
      bus(2'd3, 1'b0, 32'h0, 4'hF);
      bus(2'd3, 1'b1, 32'h3, 4'h1);

      // Timer wrap and partial-select writes ignored.
      bus(2'd0, 1'b1, 32'hFFFF_FFFE, 4'hF);
      @(posedge clk); #1;
      bus(2'd0, 1'b0, 32'h0, 4'hF);
      bus(2'd3, 1'b0, 32'h0, 4'hF);
      bus(2'd0, 1'b1, 32'h1234_5678, 4'h3);
      bus(2'd1, 1'b1, 32'h1234_5678, 4'h7);
      bus(2'd0, 1'b0, 32'h0, 4'hF);
      bus(2'd1, 1'b0, 32'h0, 4'hF);

      // PND set and clear on the same edge.
      bus(2'd1, 1'b1, tmr_at(cyc + 3), 4'hF);
      bus(2'd3, 1'b1, 32'h7, 4'h1);
      bus(2'd3, 1'b0, 32'h0, 4'hF);

      // Overflow on fifth push, then push+pop while full.
      tx_ack = 1'b0;
      for (int i = 0; i < 5; i++) bus(2'd2, 1'b1, {8'h41 + 8'(i), 24'h0}, 4'h8);
      bus(2'd2, 1'b0, 32'h0, 4'hF);
      bus(2'd3, 1'b0, 32'h0, 4'hF);
      bus(2'd3, 1'b1, 32'h4, 4'h1);
      bus(2'd2, 1'b1, 32'h4600_0000, 4'h8, 1'b1);
      bus(2'd2, 1'b0, 32'h0, 4'hF);
      bus(2'd3, 1'b0, 32'h0, 4'hF);
      tx_ack = 1'b1;
      guard = 0;
      while ((fifo_m.size() != 0 || txs) && guard < 30) begin @(posedge clk); #1; guard++; end
      tx_ack = 1'b0;
      check("drain_done", {31'h0, txs}, 32'h0);
      bus(2'd2, 1'b0, 32'h0, 4'hF);

      // Reset during a pending access.
      bus(2'd2, 1'b1, 32'h5A00_0000, 4'h8);
      bus(2'd3, 1'b1, 32'h2, 4'h1);
      adr = 2'd3; wre = 1'b1; wdat = 32'h0; sel = 4'hF; stb = 1'b1;
      do_reset(1);
      stb = 1'b0; wre = 1'b0;
      check("rst_abort_ack", {31'h0, ack}, 32'h0);
      check("rst_abort_dat", rdat, 32'h0);
      check("rst_abort_int", {31'h0, irq}, 32'h0);
      check("rst_abort_txs", {31'h0, txs}, 32'h0);
      bus(2'd1, 1'b0, 32'h0, 4'hF);
      bus(2'd3, 1'b0, 32'h0, 4'hF);

      // Randomized mix.
      for (int i = 0; i < 120; i++) begin
         int op;
         op = int'($urandom_range(0, 7));
         tx_ack = 1'($urandom_range(0, 1));
         case (op)
            0, 1: bus(2'd2, 1'b1, $urandom, ($urandom_range(0, 3) != 0) ? 4'h8 : 4'($urandom));
            2: bus(2'd2, 1'b0, 32'h0, 4'hF);
            3: bus(2'd3, 1'b0, 32'h0, 4'hF);
            4: bus(2'd1, 1'b1, $urandom, ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom));
            5: bus(2'($urandom_range(0, 1)), 1'b0, 32'h0, 4'hF);
            6: bus(2'd3, 1'b1, $urandom, 4'($urandom));
            default: bus(2'd0, 1'b1, $urandom, ($urandom_range(0, 1) != 0) ? 4'hF : 4'h1);
         endcase
      end
      tx_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("pending_acks", 32'(exp_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
